// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constants and word helpers for the AES-256 key schedule.
package aes_pkg;
   typedef logic [31:0]  word_t;
   typedef logic [127:0] rk_t;
   typedef enum logic [1:0] {IDLE, EMIT, GEN} state_t;
   localparam int NK     = 8;
   localparam int NUM_RK = 15;
   function automatic logic [7:0] rcon(input logic [2:0] n);
      return 8'h01 << (n - 3'd1);
   endfunction
   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction
endpackage

// File: rtl/aes256_key_sched_if.sv
// aes256_key_sched_if: start/key request plus the round-key valid/ready stream.
interface aes256_key_sched_if;
   import aes_pkg::*;
   logic         start;
   logic [255:0] key;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [3:0]   rk_idx;
   rk_t          rk;
   logic         done;
   modport master (output start, key, rk_ready, input busy, rk_valid, rk_idx, rk, done);
   modport slave  (input start, key, rk_ready, output busy, rk_valid, rk_idx, rk, done);
endinterface

// File: rtl/aes256_sub_word.sv
// aes256_sub_word: combinational 32-bit SubWord from four parallel S-boxes.
module aes256_sub_word
   import aes_pkg::*;
(
   input  word_t i_word,
   output word_t o_word
);
   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (.i_byte(i_word[8*g +: 8]), .o_byte(o_word[8*g +: 8]));
   end
endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: AES byte S-box, GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int k = 0; k < 8; k++) begin
         p = b[k] ? p ^ x : p;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] p, r;
      p = a;
      r = 8'h01;
      for (int k = 1; k < 8; k++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction
   logic [7:0] w_inv;
   assign w_inv  = ginv(i_byte);
   assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                 ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

// File: rtl/aes256_key_sched.sv
// aes256_key_sched: sequential AES-256 key expansion emitting rk0..rk14 over valid/ready.
// KEY_SCHED_SERIAL_SBOX_EN: one shared S-box builds each SubWord a byte per cycle.
module aes256_key_sched
   import aes_pkg::*;
(
   input  logic clk,
   input  logic rst,
   aes256_key_sched_if.slave ks
);
   state_t     r_state;
   word_t      r_w [NK];
   logic [5:0] r_i;
   logic [3:0] r_idx;
   rk_t        r_rk;
   logic       r_busy;
   logic       r_valid;
   word_t      w_src;
   word_t      w_sub;
   word_t      w_temp;
   word_t      w_new;
   logic       w_step;
   assign w_src = r_i[2] ? r_w[7] : rot_word(r_w[7]);
`ifdef KEY_SCHED_SERIAL_SBOX_EN
   logic [1:0]  r_byte;
   logic [23:0] r_sub;
   logic [7:0]  w_sb_in;
   logic [7:0]  w_sb_out;
   assign w_sb_in = w_src[{~r_byte, 3'b000} +: 8];
   aes_sbox u_sbox (.i_byte(w_sb_in), .o_byte(w_sb_out));
   assign w_sub  = {r_sub, w_sb_out};
   assign w_step = (r_state == GEN) && (r_i[1:0] != 2'd0 || r_byte == 2'd3);
   // bytes gather MSB first; the window holds still until the 4th byte lands
   always_ff @(posedge clk) begin
      if (rst) begin
         r_byte <= '0;
         r_sub  <= '0;
      end else if (r_state == GEN && r_i[1:0] == 2'd0) begin
         r_byte <= r_byte + 2'd1;
         r_sub  <= {r_sub[15:0], w_sb_out};
      end
   end
`else
   aes256_sub_word u_sub (.i_word(w_src), .o_word(w_sub));
   assign w_step = (r_state == GEN);
`endif
   assign w_temp = r_i[1:0] != 2'd0 ? r_w[7] : r_i[2] ? w_sub : w_sub ^ {rcon(r_i[5:3]), 24'h0};
   assign w_new  = r_w[0] ^ w_temp;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_i     <= '0;
         r_idx   <= '0;
         r_rk    <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         for (int k = 0; k < NK; k++) r_w[k] <= '0;
      end else begin
         case (r_state)
            IDLE: if (ks.start) begin
               for (int k = 0; k < NK; k++) r_w[k] <= ks.key[32*(7-k) +: 32];
               r_rk    <= ks.key[255:128];
               r_idx   <= '0;
               r_i     <= 6'd8;
               r_valid <= 1'b1;
               r_busy  <= 1'b1;
               r_state <= EMIT;
            end
            EMIT: if (ks.rk_ready) begin
               if (r_idx == 4'(NUM_RK - 1)) begin
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (r_idx == 4'd0) begin
                  r_idx <= 4'd1;
                  r_rk  <= {r_w[4], r_w[5], r_w[6], r_w[7]};
               end else begin
                  r_idx   <= r_idx + 4'd1;
                  r_valid <= 1'b0;
                  r_state <= GEN;
               end
            end
            GEN: if (w_step) begin
               for (int k = 0; k < NK - 1; k++) r_w[k] <= r_w[k+1];
               r_w[7] <= w_new;
               r_i    <= r_i + 6'd1;
               if (r_i[1:0] == 2'd3) begin
                  r_rk    <= {r_w[5], r_w[6], r_w[7], w_new};
                  r_valid <= 1'b1;
                  r_state <= EMIT;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign ks.busy     = r_busy;
   assign ks.rk_valid = r_valid;
   assign ks.rk_idx   = r_idx;
   assign ks.rk       = r_rk;
   assign ks.done     = (r_state == EMIT) && (r_idx == 4'(NUM_RK - 1)) && ks.rk_ready;
endmodule

// File: tb/tb_aes256_key_sched.sv
// tb_aes256_key_sched: directed checks of the AES-256 key schedule against FIPS-197 vectors.
// Honours KEY_SCHED_SERIAL_SBOX_EN for the expected stall length.
module tb_aes256_key_sched;
   import aes_pkg::*;
`ifdef KEY_SCHED_SERIAL_SBOX_EN
   localparam int GAP = 7;
`else
   localparam int GAP = 4;
`endif
   localparam int RUN_LEN = 1 + 2 + 13 * (GAP + 1);
   localparam logic [255:0] KEY_A = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] KEY_B = 256'h00112233445566778899aabbccddeeff0123456789abcdeffedcba9876543210;
   logic clk = 1'b0;
   logic rst = 1'b1;
   aes256_key_sched_if ks ();
   aes256_key_sched dut (.clk(clk), .rst(rst), .ks(ks));
   always #5 clk = ~clk;
   int   n_chk = 0;
   int   n_err = 0;
   int   done_cyc;
   logic [7:0] sb [256];
   rk_t  exp_rk [15];
   rk_t  got_rk [15];
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
      n_chk++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction
   function automatic word_t sub(input word_t x);
      return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
   endfunction
   task automatic expand(input logic [255:0] k);
      word_t w [60];
      word_t t;
      logic [7:0] rc;
      rc = 8'h01;
      for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t  = sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = rc << 1;
         end else if (i % 8 == 4) t = sub(t);
         w[i] = w[i-8] ^ t;
      end
      for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask
   // mode 0: ready high, timing checked; 1: random ready; 2: ready high plus a stray start at rk7
   task automatic run(input logic [255:0] k, input int mode);
      int   idx = 0;
      int   gap = 0;
      int   cyc = 0;
      logic stall = 1'b0;
      logic seen = 1'b0;
      rk_t  prk = '0;
      logic [3:0] pidx = '0;
      expand(k);
      ks.key      = k;
      ks.start    = 1'b1;
      ks.rk_ready = 1'b1;
      tick;
      ks.start = 1'b0;
      cyc = 1;
      check("busy_after_start", 128'(ks.busy), 128'(1'b1));
      check("rk0_valid_latency", 128'(ks.rk_valid), 128'(1'b1));
      while (!seen && cyc < 400) begin
         ks.rk_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
         ks.start    = (mode == 2) && ks.rk_valid && ks.rk_idx == 4'd7;
         if (ks.start) ks.key = KEY_B;
         #1;
         if (stall) begin
            check("stall_rk", ks.rk, prk);
            check("stall_idx", 128'(ks.rk_idx), 128'(pidx));
         end
         if (ks.rk_valid && ks.rk_ready) begin
            check("rk_idx", 128'(ks.rk_idx), 128'(idx));
            check("rk", ks.rk, exp_rk[idx]);
            got_rk[idx] = ks.rk;
            if (mode == 0 && idx > 0) check("gap", 128'(gap), 128'(idx == 1 ? 0 : GAP));
            check("done", 128'(ks.done), 128'(idx == 14));
            seen = (idx == 14);
            if (seen) done_cyc = cyc;
            idx++;
            gap = 0;
         end else if (!ks.rk_valid) gap++;
         stall = ks.rk_valid && !ks.rk_ready;
         prk   = ks.rk;
         pidx  = ks.rk_idx;
         if (!seen) begin
            tick;
            cyc++;
         end
      end
      ks.start = 1'b0;
      check("done_seen", 128'(seen), 128'(1'b1));
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      for (int b = 0; b < 256; b++) begin
         logic [7:0] inv;
         inv = '0;
         for (int c = 1; c < 256; c++) if (gm(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
         sb[b] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
      ks.start    = 1'b0;
      ks.key      = '0;
      ks.rk_ready = 1'b0;
      repeat (3) tick;
      check("rst_busy", 128'(ks.busy), 128'(1'b0));
      check("rst_valid", 128'(ks.rk_valid), 128'(1'b0));
      check("rst_idx", 128'(ks.rk_idx), 128'(4'd0));
      check("rst_rk", ks.rk, 128'h0);
      check("rst_done", 128'(ks.done), 128'(1'b0));
      rst = 1'b0;
      tick;
      run(KEY_A, 0);
      check("fips_rk0", got_rk[0], 128'h603deb1015ca71be2b73aef0857d7781);
      check("fips_rk2", got_rk[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
      check("fips_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
      check("done_cycle", 128'(done_cyc), 128'(RUN_LEN - 1));
      tick;
      check("busy_gap", 128'(ks.busy), 128'(1'b0));
      check("idle_valid", 128'(ks.rk_valid), 128'(1'b0));
      run(KEY_A, 1);
      tick;
      run(KEY_A, 2);
      check("restart_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
      tick;
      ks.key      = KEY_A;
      ks.start    = 1'b1;
      ks.rk_ready = 1'b1;
      tick;
      ks.start = 1'b0;
      for (int c = 0; c < 200 && !(ks.rk_idx == 4'd9 && !ks.rk_valid); c++) tick;
      check("abort_idx", 128'(ks.rk_idx), 128'(4'd9));
      check("abort_in_gen", 128'(ks.rk_valid), 128'(1'b0));
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("abort_busy", 128'(ks.busy), 128'(1'b0));
      check("abort_valid", 128'(ks.rk_valid), 128'(1'b0));
      check("abort_idx0", 128'(ks.rk_idx), 128'(4'd0));
      check("abort_rk", ks.rk, 128'h0);
      check("abort_done", 128'(ks.done), 128'(1'b0));
      repeat (10) begin
         tick;
         check("no_rk_after_abort", 128'(ks.rk_valid), 128'(1'b0));
      end
      run('0, 0);
      check("zero_key_rk2", got_rk[2], 128'h62636363626363636263636362636363);
      tick;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/aes256_key_sched.md
Name: aes256_key_sched

Overview:
Sequential AES-256 key-expansion controller. It takes a 256-bit cipher key and produces the 15 round keys (rk0..rk14) one at a time over a valid/ready stream. The round datapath consumes them, or a round-key store loads them. SubWord is computed by instancing the existing byte S-box, four in parallel by default. Words are generated one per cycle into an 8-word sliding window.

Parameters:
NUM_RK, 15, number of round keys emitted; fixed for AES-256, rk index width 4.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  begin expansion of key; sampled only in IDLE
key  in  256  cipher key; key[255:224] = w0, MSB-first bytes (FIPS-197 order)
busy  out  1  high from the cycle after accepted start until the done cycle, inclusive
rk_valid  out  1  round key presented
rk_ready  in  1  consumer accepts rk when rk_valid && rk_ready
rk_idx  out  4  index of presented round key, 0..14
rk  out  128  round key; rk[127:96] = w[4*rk_idx]
done  out  1  one-cycle pulse in the cycle rk14 is accepted

Behaviour:
- Reset: state=IDLE; busy=0, rk_valid=0, rk_idx=0, rk=0, done=0; window and counters cleared. Reset mid-operation aborts; no further rk is emitted.
- Window: 8 x 32-bit shift register W[0..7]. W[7] is the newest word. Word counter i runs 8..59 (6 bits).
- Word generation: temp = W[7].
  - i%8==0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/8],24'h0}.
  - i%8==4: temp = SubWord(temp).
  - new = W[0] ^ temp; the window shifts left by one word.
- Rcon[1..7] = 01,02,04,08,10,20,40.
- FSM states:
  - IDLE: start=1 loads key into the window, rk_idx<=0, goto EMIT. start=0 stays.
  - EMIT: rk_valid=1. rk = W[0..3] when rk_idx==0, else W[4..7]. On handshake:
    - rk_idx==14: goto IDLE, done=1, busy drops the following cycle.
    - rk_idx==0: rk_idx<=1, stay in EMIT. rk1 is valid the next cycle.
    - otherwise: rk_idx++, goto GEN.
  - GEN: one word per cycle, 4 cycles (gen counter 0..3). Then goto EMIT; rk_valid rises the cycle after the 4th word is written.
- Latency: start to rk0 valid = 1 cycle. rk(n) accept to rk(n+1) valid = 1 cycle for n=0, 5 cycles for n>=1. Full run with rk_ready tied high = 1 + 2 + 13*5 = 68 cycles.
- Backpressure: while rk_valid && !rk_ready, rk and rk_idx hold stable and the window does not advance.
- start while busy is ignored; key is sampled only on the IDLE->EMIT transition.
- done and start in the same cycle: start is ignored because the FSM is not yet in IDLE.

Optional Feature:
KEY_SCHED_SERIAL_SBOX_EN
- Defined: one S-box instance. The sub-word for a word with i%4==0 is built one byte per cycle over 4 cycles (byte counter 0..3, MSB byte first) into a temp register; the XOR and shift occur in the 4th cycle. Words with i%4!=0 still take 1 cycle.
- GEN then lasts 7 cycles per round key. Accept-to-valid becomes 8 cycles for n>=1; full run = 1 + 2 + 13*8 = 107 cycles.
- Undefined: four S-box instances, timing as in Behaviour.
- Outputs and ordering are identical in both builds.

Decomposition:
- Package aes_pkg holds:
  - word typedef (32-bit) and round-key typedef (128-bit);
  - constants NK=8 and NUM_RK=15;
  - the Rcon lookup function;
  - the RotWord function.
- Sub-module aes256_sub_word: 4 x sbox, combinational 32-bit SubWord. It is used in the default build and bypassed in the serial build.

Test Plan:
1. FIPS-197 A.3 key 603deb1015ca71be2b73aef0857d7781 1f352c073b6108d72d9810a30914dff4, rk_ready=1 -> rk0 = 603deb1015ca71be2b73aef0857d7781; rk2 = 9ba354118e6925afa51a8b5f2067fcde; rk14 = fe4890d1e6188d0b046df344706c631e; done at cycle 68 after start (107 in the serial build).
2. Same key with rk_ready toggled pseudo-randomly -> identical rk sequence; rk and rk_idx stable during every stall cycle; no index skipped or repeated.
3. start pulsed again at rk_idx=7 with a different key -> ignored; sequence completes with the original key values.
4. rst asserted during GEN at rk_idx=9 -> next cycle all outputs are 0. A new start with key=0 then yields rk2 = 62636363626363636263636362636363.
5. Back-to-back runs: start asserted in the cycle after done -> accepted; rk0 valid 1 cycle later; busy low for exactly that one cycle.
6. Latency check with rk_ready=1 -> exactly 4 (or 7 serial) rk_valid-low cycles between consecutive keys from rk1 onward; 0 between rk0 and rk1.
